// File: rtl/bmf_h_stream_decoder_pkg.sv
// Shared types, default sizes and decode helpers for the BMF H-side stream decoder.
package bmf_h_stream_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int BMF_K     = 4;
    localparam int BMF_M     = 5;
    localparam int BMF_ERR_W = 16;

    // Helpers work on fixed maximum widths; callers zero-pad and truncate.
    localparam int BMF_K_MAX = 16;
    localparam int BMF_M_MAX = 32;
    localparam int BMF_PC_W  = $clog2(BMF_M_MAX + 1);

    // out[j] = OR_i (k[i] & H[i][j]) -- pure AND/OR, no arithmetic.
    function automatic logic [BMF_M_MAX-1:0] bmf_decode(
        input logic [BMF_K_MAX-1:0]                k,
        input logic [BMF_K_MAX-1:0][BMF_M_MAX-1:0] h
    );
        logic [BMF_M_MAX-1:0] o;
        o = '0;
        for (int j = 0; j < BMF_M_MAX; j++) begin
            for (int i = 0; i < BMF_K_MAX; i++) begin
                o[j] = o[j] | (k[i] & h[i][j]);
            end
        end
        return o;
    endfunction

    function automatic logic [BMF_PC_W-1:0] bmf_popcount(input logic [BMF_M_MAX-1:0] v);
        logic [BMF_PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < BMF_M_MAX; i++) begin
            c = c + BMF_PC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bmf_h_stream_decoder_if.sv
// Configuration, latent-input and reconstructed-output bundle of the decoder.
// Handshake rule for both streams: a word transfers on a rising clock edge where
// valid && ready are both high; the producer holds valid and data stable until then,
// and valid never depends on ready.
interface bmf_h_stream_decoder_if
    import bmf_h_stream_decoder_pkg::*;
#(
    parameter int K     = BMF_K,
    parameter int M     = BMF_M,
    parameter int ERR_W = BMF_ERR_W
);
    localparam int ROW_W = (K > 1) ? $clog2(K) : 1;

    logic             cfg_we;
    logic [ROW_W-1:0] cfg_row;
    logic [M-1:0]     cfg_data;
    logic             cfg_commit;
    logic             cfg_busy;
    logic             in_valid;
    logic             in_ready;
    logic [K-1:0]     in_k;
    logic [M-1:0]     in_exact;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_data;
    logic [ERR_W-1:0] err_bits;

    modport master (
        output cfg_we, cfg_row, cfg_data, cfg_commit, in_valid, in_k, in_exact, out_ready,
        input  cfg_busy, in_ready, out_valid, out_data, err_bits
    );

    modport slave (
        input  cfg_we, cfg_row, cfg_data, cfg_commit, in_valid, in_k, in_exact, out_ready,
        output cfg_busy, in_ready, out_valid, out_data, err_bits
    );
endinterface

// File: rtl/bmf_h_stream_decoder_pipe_stage.sv
// One-entry valid/ready register slice. Accepts a new word whenever it is empty
// or its current word leaves in the same cycle, giving full throughput.
module bmf_h_stream_decoder_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load or hold the slice; data only changes when a new word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end
endmodule

// File: rtl/bmf_h_stream_decoder.sv
// Streaming BMF decompressor: out = OR of the active-basis rows selected by k,
// with a double-buffered H basis, a two-stage pipeline and Hamming-error accounting.
module bmf_h_stream_decoder
    import bmf_h_stream_decoder_pkg::*;
#(
    parameter int K     = BMF_K,
    parameter int M     = BMF_M,
    parameter int ERR_W = BMF_ERR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bmf_h_stream_decoder_if.slave bus,
    output state_t               dbg_state
);
    localparam int ROW_W = (K > 1) ? $clog2(K) : 1;
    localparam int PC_W  = $clog2(M + 1);
    localparam int SUM_W = ERR_W + 1;

    state_t state, state_nxt;

    logic [K-1:0][M-1:0]                shadow_h;
    logic [K-1:0][M-1:0]                active_h;
    logic [BMF_K_MAX-1:0][BMF_M_MAX-1:0] h_pad;

    logic             s1_in_valid, s1_in_ready, s1_valid;
    logic [K+M-1:0]   s1_data;
    logic [K-1:0]     s1_k;
    logic [M-1:0]     s1_exact;
    logic [M-1:0]     dec;
    logic             s2_in_ready, s2_valid;
    logic [2*M-1:0]   s2_data;
    logic [M-1:0]     exact_s2;
    logic             pipe_empty;

    logic [ERR_W-1:0] err_q;
    logic [PC_W-1:0]  err_pc;
    logic [SUM_W-1:0] err_sum;

    assign dbg_state  = state;
    assign pipe_empty = !s1_valid && !s2_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a commit always drains in-flight words before the basis swap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cfg_commit) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (bus.cfg_commit) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cfg_busy = (state == DRAIN) || (state == LOAD);
    assign s1_in_valid  = bus.in_valid && (state == RUN);
    assign bus.in_ready = (state == RUN) && s1_in_ready;

    // Shadow rows are writable in every state; the active bank copies the shadow only in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_h <= '0;
            active_h <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (bus.cfg_we && (bus.cfg_row == ROW_W'(i))) begin
                    shadow_h[i] <= bus.cfg_data;
                end
            end
            if (state == LOAD) begin
                active_h <= shadow_h;
            end
        end
    end

    // Zero-pad the active basis to the helper's fixed width.
    always_comb begin
        h_pad = '0;
        for (int i = 0; i < K; i++) begin
            h_pad[i] = BMF_M_MAX'(active_h[i]);
        end
    end

    bmf_h_stream_decoder_pipe_stage #(.W(K + M)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_data   ({bus.in_k, bus.in_exact}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign s1_k     = s1_data[K+M-1:M];
    assign s1_exact = s1_data[M-1:0];
    // Decoded on the S1->S2 transfer, so the word is bound to the basis active at that moment.
    assign dec      = M'(bmf_decode(BMF_K_MAX'(s1_k), h_pad));

    bmf_h_stream_decoder_pipe_stage #(.W(2 * M)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({dec, s1_exact}),
        .out_valid (s2_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_data)
    );

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data[2*M-1:M];
    assign exact_s2      = s2_data[M-1:0];

    assign err_pc  = PC_W'(bmf_popcount(BMF_M_MAX'(bus.out_data ^ exact_s2)));
    assign err_sum = SUM_W'(err_q) + SUM_W'(err_pc);

    // Saturating accumulation of bit errors over delivered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            err_q <= err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
        end
    end

    assign bus.err_bits = err_q;
endmodule

// File: tb/tb_bmf_h_stream_decoder.sv
// Self-checking bench for bmf_h_stream_decoder: vector table, hand sequences for
// latency/backpressure/commit/reset corners, and randomized streams against a model.
module tb_bmf_h_stream_decoder;
    import bmf_h_stream_decoder_pkg::*;

    localparam int K     = 4;
    localparam int M     = 5;
    localparam int ERR_W = 16;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    bmf_h_stream_decoder_if #(.K(K), .M(M), .ERR_W(ERR_W)) bus ();

    bmf_h_stream_decoder #(.K(K), .M(M), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [2*M-1:0]      exp_q[$];
    logic [K-1:0][M-1:0] m_shadow;
    logic [K-1:0][M-1:0] m_active;
    logic [ERR_W-1:0]    m_err;
    bit                  mon_en;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: OR together the basis rows selected by the set bits of k.
    function automatic logic [M-1:0] ref_decode(logic [K-1:0][M-1:0] h, logic [K-1:0] k);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) begin
            if (k[i]) r = r | h[i];
        end
        return r;
    endfunction

    // Monitor: expected words enter on input handshakes, leave on output handshakes.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            logic [2*M-1:0] e;
            int s;
            chk("err_bits", bus.err_bits, m_err);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[2*M-1:M]);
                    s = int'(m_err) + $countones(e[2*M-1:M] ^ e[M-1:0]);
                    m_err = (s > (1 << ERR_W) - 1) ? {ERR_W{1'b1}} : ERR_W'(s);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({ref_decode(m_active, bus.in_k), bus.in_exact});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_row(int row, logic [M-1:0] data);
        @(posedge clk); #1;
        bus.cfg_we   = 1'b1;
        bus.cfg_row  = 2'(row);
        bus.cfg_data = data;
        m_shadow[row] = data;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic commit(bit with_write, int row, logic [M-1:0] data);
        bit ok;
        @(posedge clk); #1;
        bus.cfg_commit = 1'b1;
        if (with_write) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_row  = 2'(row);
            bus.cfg_data = data;
            m_shadow[row] = data;
        end
        @(posedge clk); #1;
        bus.cfg_commit = 1'b0;
        bus.cfg_we     = 1'b0;
        @(negedge clk);
        chk("commit_busy", bus.cfg_busy, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.cfg_busy && dbg_state == RUN) begin
                ok = 1;
                break;
            end
        end
        chk("commit_done", ok, 1);
        m_active = m_shadow;
    endtask

    // Single word into an empty pipeline with out_ready=1: visible exactly two cycles later.
    task automatic send_check(logic [K-1:0] k, logic [M-1:0] exact, logic [M-1:0] exp, string name);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_k     = k;
        bus.in_exact = exact;
        @(negedge clk);
        chk({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat_t1"}, bus.out_valid, 0);
        @(negedge clk);
        chk({name, "_lat_t2"}, bus.out_valid, 1);
        chk({name, "_data"}, bus.out_data, exp);
    endtask

    task automatic stream(int n, bit rnd_rdy, bit use_fixed, logic [M-1:0] fixed_exact);
        int sent = 0;
        int guard = 0;
        bit acc;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_k     = K'($urandom);
        bus.in_exact = use_fixed ? fixed_exact : M'($urandom);
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        while (sent < n && guard < n * 8 + 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                sent++;
                bus.in_k     = K'($urandom);
                bus.in_exact = use_fixed ? fixed_exact : M'($urandom);
            end
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_sent", sent, n);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [K-1:0][M-1:0] h;
        logic [K-1:0]        k;
        logic [M-1:0]        exp;
    } vec_t;

    vec_t tbl[6];

    // ---------------- main sequence ----------------
    initial begin
        logic [K-1:0][M-1:0] id_h;
        logic [K-1:0][M-1:0] ov_h;
        logic [M-1:0]        held;
        logic [K-1:0]        x0;
        int                  n_sat;

        id_h = {5'b10000, 5'b01000, 5'b00100, 5'b00010};
        ov_h = {5'b00000, 5'b00000, 5'b00110, 5'b00011};
        tbl[0] = '{h: id_h, k: 4'b1010, exp: 5'b10100};
        tbl[1] = '{h: id_h, k: 4'b0000, exp: 5'b00000};
        tbl[2] = '{h: id_h, k: 4'b1111, exp: 5'b11110};
        tbl[3] = '{h: ov_h, k: 4'b0011, exp: 5'b00111};
        tbl[4] = '{h: ov_h, k: 4'b0010, exp: 5'b00110};
        tbl[5] = '{h: ov_h, k: 4'b1100, exp: 5'b00000};

        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_row    = '0;
        bus.cfg_data   = '0;
        bus.cfg_commit = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_k       = '0;
        bus.in_exact   = '0;
        bus.out_ready  = 1'b1;
        m_shadow       = '0;
        m_active       = '0;
        m_err          = '0;
        mon_en         = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_cfg_busy", bus.cfg_busy, 0);
        chk("rst_err_bits", bus.err_bits, 0);
        chk("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Nothing accepted before the first commit
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Table: rows 0..K-2 written, last row written in the commit cycle
        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < K - 1; r++) write_row(r, tbl[v].h[r]);
            commit(1'b1, K - 1, tbl[v].h[K-1]);
            send_check(tbl[v].k, M'($urandom), tbl[v].exp, "tbl");
        end

        // Async reset while backpressured
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_k      = 4'b0011;
        repeat (3) @(posedge clk);
        #1;
        chk("rstbp_pre_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstbp_out_valid", bus.out_valid, 0);
        chk("rstbp_out_data", bus.out_data, 0);
        chk("rstbp_in_ready", bus.in_ready, 0);
        chk("rstbp_err_bits", bus.err_bits, 0);
        chk("rstbp_busy", bus.cfg_busy, 0);
        exp_q.delete();
        m_err         = '0;
        m_shadow      = '0;
        m_active      = '0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_in_ready", bus.in_ready, 0);
            chk("post_rst_state", dbg_state, IDLE);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        commit(1'b0, 0, '0);
        send_check(4'b1111, 5'b00000, 5'b00000, "basis_cleared");

        // Error accounting: identity basis, exact all ones -> +3 per word
        for (int r = 0; r < K - 1; r++) write_row(r, id_h[r]);
        commit(1'b1, K - 1, id_h[K-1]);
        send_check(4'b1010, 5'b11111, 5'b10100, "err_w0");
        send_check(4'b1010, 5'b11111, 5'b10100, "err_w1");
        repeat (2) @(negedge clk);
        chk("err_plus_3x2", bus.err_bits, 6);

        // Eight back-to-back words must come out on eight consecutive cycles
        fork
            stream(8, 1'b0, 1'b0, '0);
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                chk("stream8_first", seen, 1);
                for (int i = 1; i < 8; i++) begin
                    @(negedge clk);
                    chk("stream8_consecutive", bus.out_valid, 1);
                end
            end
        join
        drain();

        // Backpressure: S2 then S1 fill, output held, input stalls
        x0 = 4'b0110;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_k      = x0;
        bus.in_exact  = M'($urandom);
        @(negedge clk);
        chk("bp_acc0", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_k = 4'b1001;
        @(negedge clk);
        chk("bp_acc1", bus.in_ready, 1);
        chk("bp_s2_empty", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.in_k = 4'b0101;
        held = ref_decode(m_active, x0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_data", bus.out_data, held);
            chk("bp_stall", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // Commit with two words in flight
        for (int r = 0; r < K; r++) write_row(r, M'($urandom));
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_k     = 4'b1111;
        bus.in_exact = '0;
        @(posedge clk); #1;
        bus.in_k       = 4'b0101;
        bus.cfg_commit = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.cfg_commit = 1'b0;
        @(negedge clk);
        chk("mid_busy", bus.cfg_busy, 1);
        chk("mid_in_ready", bus.in_ready, 0);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!bus.cfg_busy && dbg_state == RUN) begin
                    ok = 1;
                    break;
                end
            end
            chk("mid_commit_done", ok, 1);
        end
        m_active = m_shadow;
        send_check(4'b1111, '0, ref_decode(m_active, 4'b1111), "mid_new_h");

        // Randomized streams with random backpressure over two random bases
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < K; r++) write_row(r, M'($urandom));
            commit(1'b0, 0, '0);
            stream(150, 1'b1, 1'b0, '0);
            drain();
        end

        // Saturation: zero basis, exact all ones -> +5 per word until the counter pins
        for (int r = 0; r < K - 1; r++) write_row(r, '0);
        commit(1'b1, K - 1, '0);
        n_sat = ((1 << ERR_W) - 1 - int'(m_err)) / 5 + 3;
        stream(n_sat, 1'b0, 1'b1, 5'b11111);
        drain();
        chk("err_saturated", bus.err_bits, {ERR_W{1'b1}});

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
